// File: rtl/pipe_mem_stage.sv
// MEM-stage data-access controller: drives the data-memory req/ack bus,
// stalls the pipeline until the access completes, and aligns load data.
module pipe_mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Mvalid,
    input  logic [3:0]  Mmemop,
    input  logic [31:0] Malu,
    input  logic [31:0] Mb,
    output logic [31:0] Mdm,
    output logic        mem_stall,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        is_b, is_h, is_w, is_st;
    logic        access, misal, go;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        is_b  = 1'b0;
        is_h  = 1'b0;
        is_w  = 1'b0;
        is_st = 1'b0;
        case (Mmemop)
            4'd1, 4'd2: is_b = 1'b1;
            4'd3, 4'd4: is_h = 1'b1;
            4'd5:       is_w = 1'b1;
            4'd6: begin is_b = 1'b1; is_st = 1'b1; end
            4'd7: begin is_h = 1'b1; is_st = 1'b1; end
            4'd8: begin is_w = 1'b1; is_st = 1'b1; end
            default: ;
        endcase
    end

    assign access = Mvalid & (is_b | is_h | is_w);
    assign misal  = access & ((is_h & Malu[0]) | (is_w & (|Malu[1:0])));
    assign go     = access & ~misal;

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = Mb;
        unique case (1'b1)
            is_b: begin
                be_n    = 4'b0001 << Malu[1:0];
                wdata_n = {4{Mb[7:0]}};
            end
            is_h: begin
                be_n    = Malu[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{Mb[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dm_rdata[7:0];
        case (off_q)
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            2'd3:    ld_byte = dm_rdata[31:24];
            default: ld_byte = dm_rdata[7:0];
        endcase
        ld_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (op_q)
            4'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            4'd2:    ld_data = {24'd0, ld_byte};
            4'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            4'd4:    ld_data = {16'd0, ld_half};
            4'd5:    ld_data = dm_rdata;
            default: ld_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        off_d     = off_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        unique case (state_q)
            IDLE: begin
                rdata_d = 32'd0;
                if (go) begin
                    state_d = REQ;
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    we_d    = is_st;
                    be_d    = be_n;
                    addr_d  = {Malu[31:2], 2'b00};
                    wdata_d = wdata_n;
                    op_d    = Mmemop;
                    off_d   = Malu[1:0];
                end
            end
            REQ: begin
                // ack beats a timeout landing in the same cycle
                if (dm_ack) begin
                    rdata_d = ld_data;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    rdata_d   = 32'd0;
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            op_q      <= 4'd0;
            off_q     <= 2'd0;
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            off_q     <= off_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem_stall = ~rst & (((state_q == IDLE) & go) | (state_q == REQ));
    assign addr_err  = misal;
    assign Mdm       = (state_q == DONE) ? rdata_q : 32'd0;
    assign bus_err   = bus_err_q;
    assign dm_req    = req_q;
    assign dm_we     = we_q;
    assign dm_be     = be_q;
    assign dm_addr   = addr_q;
    assign dm_wdata  = wdata_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage: table of aligned accesses plus
// misaligned, timeout, late-ack, stray-ack and mid-request reset sequences.
module tb_pipe_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        Mvalid;
    logic [3:0]  Mmemop;
    logic [31:0] Malu;
    logic [31:0] Mb;
    logic [31:0] Mdm;
    logic        mem_stall;
    logic        addr_err;
    logic        bus_err;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_mem_stage #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .Mvalid(Mvalid), .Mmemop(Mmemop),
        .Malu(Malu), .Mb(Mb), .Mdm(Mdm), .mem_stall(mem_stall),
        .addr_err(addr_err), .bus_err(bus_err), .dm_req(dm_req),
        .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] mb;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] mdm;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int stalls = 0;
        @(negedge clk);
        Mvalid = 1'b1; Mmemop = v.op; Malu = v.addr; Mb = v.mb;
        dm_ack = 1'b0; dm_rdata = 32'hAAAA_AAAA;
        #1;
        chk("idle_stall", 32'(mem_stall), 32'd1);
        chk("idle_req", 32'(dm_req), 32'd0);
        if (mem_stall) stalls++;
        for (int i = 1; i <= v.dly; i++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            chk("req_high", 32'(dm_req), 32'd1);
            if (i == 1) begin
                chk("be", 32'(dm_be), 32'(v.be));
                chk("addr", dm_addr, {v.addr[31:2], 2'b00});
                chk("wdata", dm_wdata, v.wdata);
                chk("we", 32'(dm_we), 32'(v.we));
            end
            if (i == v.dly) begin
                dm_ack = 1'b1;
                dm_rdata = v.rdata;
            end
        end
        @(negedge clk);
        dm_ack = 1'b0; dm_rdata = 32'h5555_5555;
        chk("done_stall", 32'(mem_stall), 32'd0);
        chk("done_mdm", Mdm, v.mdm);
        chk("done_buserr", 32'(bus_err), 32'd0);
        chk("done_req", 32'(dm_req), 32'd0);
        chk("stall_cycles", 32'(stalls), 32'(1 + v.dly));
        Mvalid = 1'b0; Mmemop = 4'd0;
        @(negedge clk);
        chk("after_mdm", Mdm, 32'd0);
        chk("after_stall", 32'(mem_stall), 32'd0);
    endtask

    task automatic run_misal(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        Mvalid = 1'b1; Mmemop = op; Malu = a; Mb = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mis_err", 32'(addr_err), 32'd1);
            chk("mis_req", 32'(dm_req), 32'd0);
            chk("mis_stall", 32'(mem_stall), 32'd0);
            chk("mis_mdm", Mdm, 32'd0);
            @(negedge clk);
        end
        Mvalid = 1'b0; Mmemop = 4'd0;
    endtask

    initial begin
        int reqs;
        Mvalid = 1'b0; Mmemop = 4'd0; Malu = 32'd0; Mb = 32'd0;
        dm_ack = 1'b0; dm_rdata = 32'd0;
        rst = 1'b1;

        vecs[0]  = '{4'd5, 32'h100, 32'h0, 32'hDEADBEEF, 1,
                     32'hDEADBEEF, 4'b1111, 32'h0, 1'b0};
        vecs[1]  = '{4'd1, 32'h103, 32'h0, 32'h80FF7F01, 1,
                     32'hFFFFFF80, 4'b1000, 32'h0, 1'b0};
        vecs[2]  = '{4'd2, 32'h103, 32'h0, 32'h80FF7F01, 2,
                     32'h00000080, 4'b1000, 32'h0, 1'b0};
        vecs[3]  = '{4'd3, 32'h102, 32'h0, 32'h80FF7F01, 1,
                     32'hFFFF80FF, 4'b1100, 32'h0, 1'b0};
        vecs[4]  = '{4'd4, 32'h100, 32'h0, 32'h80FF7F01, 3,
                     32'h00007F01, 4'b0011, 32'h0, 1'b0};
        vecs[5]  = '{4'd1, 32'h100, 32'h0, 32'h80FF7F01, 1,
                     32'h00000001, 4'b0001, 32'h0, 1'b0};
        vecs[6]  = '{4'd6, 32'h101, 32'h12345678, 32'hFFFFFFFF, 3,
                     32'h0, 4'b0010, 32'h78787878, 1'b1};
        vecs[7]  = '{4'd7, 32'h102, 32'h12345678, 32'hFFFFFFFF, 1,
                     32'h0, 4'b1100, 32'h56785678, 1'b1};
        vecs[8]  = '{4'd8, 32'h104, 32'h12345678, 32'hFFFFFFFF, 2,
                     32'h0, 4'b1111, 32'h12345678, 1'b1};
        vecs[9]  = '{4'd5, 32'h208, 32'h0, 32'hCAFEF00D, 15,
                     32'hCAFEF00D, 4'b1111, 32'h0, 1'b0};
        vecs[10] = '{4'd3, 32'h100, 32'h0, 32'h1234F00F, 1,
                     32'hFFFFF00F, 4'b0011, 32'h0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_mdm", Mdm, 32'd0);
        chk("rst_be", 32'(dm_be), 32'd0);
        chk("rst_buserr", 32'(bus_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        run_misal(4'd5, 32'h102);
        run_misal(4'd7, 32'h101);

        // stray ack with no request outstanding
        @(negedge clk);
        dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("stray_req", 32'(dm_req), 32'd0);
        chk("stray_stall", 32'(mem_stall), 32'd0);
        chk("stray_mdm", Mdm, 32'd0);

        // timeout
        @(negedge clk);
        Mvalid = 1'b1; Mmemop = 4'd5; Malu = 32'h200;
        reqs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!dm_req) break;
            reqs++;
        end
        chk("to_req_cycles", 32'(reqs), 32'd15);
        chk("to_buserr", 32'(bus_err), 32'd1);
        chk("to_mdm", Mdm, 32'd0);
        chk("to_stall", 32'(mem_stall), 32'd0);
        Mvalid = 1'b0; Mmemop = 4'd0;
        @(negedge clk);
        chk("to_pulse_end", 32'(bus_err), 32'd0);

        // reset in the 3rd REQ cycle
        @(negedge clk);
        Mvalid = 1'b1; Mmemop = 4'd8; Malu = 32'h300; Mb = 32'h1;
        repeat (3) @(negedge clk);
        chk("pre_rst_req", 32'(dm_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(dm_req), 32'd0);
        chk("mid_rst_stall", 32'(mem_stall), 32'd0);
        chk("mid_rst_we", 32'(dm_we), 32'd0);
        Mvalid = 1'b0; Mmemop = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        dm_ack = 1'b1;
        repeat (2) @(negedge clk);
        dm_ack = 1'b0;
        chk("post_rst_req", 32'(dm_req), 32'd0);
        chk("post_rst_mdm", Mdm, 32'd0);
        chk("post_rst_buserr", 32'(bus_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
